// File: rtl/mos6502s_bus_pkg.sv
// Shared definitions for the mos6502s bus responder: FSM state encoding,
// wait-counter width and the zero-page address decode.
package mos6502s_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } bus_state_e;

  localparam int WAIT_W = 4;

  function automatic logic is_zero_page(input logic [15:0] a);
    return (a[15:8] == 8'h00);
  endfunction

endpackage

// File: rtl/mos6502s_ram_array.sv
// Byte-wide storage for the bus responder: one write port shared by the bus
// commit and the load port (bus first), one registered read port.
module mos6502s_ram_array
  import mos6502s_bus_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bus_we,
  input  logic          bus_re,
  input  logic [AW-1:0] bus_addr,
  input  logic [7:0]    bus_wdata,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic [7:0]    rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [7:0]    mem [DEPTH];
  logic          we_s;
  logic [AW-1:0] waddr_s;
  logic [7:0]    wdata_s;
  logic [7:0]    rdata_r;

  // Write-port arbitration: a bus commit on the same edge overrides the load port.
  always_comb begin
    we_s    = bus_we | ld_we;
    waddr_s = ld_addr;
    wdata_s = ld_data;
    if (bus_we) begin
      waddr_s = bus_addr;
      wdata_s = bus_wdata;
    end else begin
      waddr_s = ld_addr;
      wdata_s = ld_data;
    end
  end

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[waddr_s] <= wdata_s;
    end
  end

  // Read register: samples pre-edge contents and holds until the next bus read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= 8'h00;
    end else if (bus_re) begin
      rdata_r <= mem[bus_addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mos6502s_bus_responder.sv
// Memory-side responder for the mos6502s CPU bus: accepts one read or write,
// inserts zero-page/normal wait states, then pulses mem_ready for one cycle.
module mos6502s_bus_responder
  import mos6502s_bus_pkg::*;
#(
  parameter int RAM_AW      = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int ZP_WAIT     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        mem_ready,
  output logic        busy,
  output logic        bus_err,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic [31:0] access_count
);

  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] ZP_LD   = WAIT_W'(ZP_WAIT);

  bus_state_e        state_r;
  logic [WAIT_W-1:0] cnt_r;
  logic [RAM_AW-1:0] addr_r;
  logic [7:0]        wdata_r;
  logic              write_r;
  logic              mem_ready_r;
  logic              busy_r;
  logic              bus_err_r;
  logic [31:0]       count_r;
  logic              commit_s;
  logic              bus_we_s;
  logic              bus_re_s;

  // The access happens on the edge that leaves BUSY with an exhausted counter.
  assign commit_s = (state_r == ST_BUSY) && (cnt_r == {WAIT_W{1'b0}});
  assign bus_we_s = commit_s & write_r;
  assign bus_re_s = commit_s & ~write_r;

  // Request FSM with wait counter, latched request and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {WAIT_W{1'b0}};
      addr_r      <= {RAM_AW{1'b0}};
      wdata_r     <= 8'h00;
      write_r     <= 1'b0;
      mem_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      bus_err_r   <= 1'b0;
      count_r     <= 32'h0000_0000;
    end else begin
      mem_ready_r <= 1'b0;
      bus_err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mem_read ^ mem_write) begin
            addr_r  <= addr[RAM_AW-1:0];
            wdata_r <= wdata;
            write_r <= mem_write;
            cnt_r   <= is_zero_page(addr) ? ZP_LD : WAIT_LD;
            busy_r  <= 1'b1;
            state_r <= ST_BUSY;
          end else if (mem_read & mem_write) begin
            bus_err_r <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r != {WAIT_W{1'b0}}) begin
            cnt_r <= cnt_r - {{(WAIT_W-1){1'b0}}, 1'b1};
          end else begin
            mem_ready_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Leave unconditionally so a request still held here is not re-accepted.
          count_r <= count_r + 32'd1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  mos6502s_ram_array #(
    .AW(RAM_AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .bus_we    (bus_we_s),
    .bus_re    (bus_re_s),
    .bus_addr  (addr_r),
    .bus_wdata (wdata_r),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr[RAM_AW-1:0]),
    .ld_data   (ld_data),
    .rdata     (rdata)
  );

  assign mem_ready    = mem_ready_r;
  assign busy         = busy_r;
  assign bus_err      = bus_err_r;
  assign access_count = count_r;

endmodule
